// File: rtl/burst_rr_arbiter_if.sv
// burst_rr_arbiter_if: request/grant bundle between requesters and the burst round-robin arbiter
interface burst_rr_arbiter_if #(
  parameter int N = 4,
  parameter int MAX_BURST = 8
);
  localparam int W = $clog2(N);
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [N-1:0] request;
  logic [N-1:0] last;
  logic [N-1:0] grant;
  logic [W-1:0] grant_id;
  logic busy;
  logic [CW-1:0] burst_cnt;
  modport master (output request, last, input grant, grant_id, busy, burst_cnt);
  modport slave (input request, last, output grant, grant_id, busy, burst_cnt);
endinterface

// File: rtl/burst_rr_arbiter.sv
// burst_rr_arbiter: registered round-robin arbiter holding the grant for a whole burst
// Define ARB_BURST_LIMIT_EN to force release once burst_cnt reaches MAX_BURST.
module burst_rr_arbiter #(
  parameter int N = 4,
  parameter int MAX_BURST = 8
) (
  input logic clk,
  input logic rst,
  burst_rr_arbiter_if.slave bus
);
  localparam int W = $clog2(N);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, OWN} state_t;
  state_t state, state_n;
  logic [W-1:0] owner, owner_n, ptr, ptr_n, win;
  logic [CW-1:0] cnt, cnt_n;
  logic found, rel, lim;
`ifdef ARB_BURST_LIMIT_EN
  assign lim = cnt == CW'(MAX_BURST);
`else
  assign lim = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
    end
  end
  // Scan backwards so the last hit is the first set bit in search order from ptr.
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.request[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        win = W'((int'(ptr) + k) % N);
      end
    end
    rel = state == IDLE || !bus.request[owner] || bus.last[owner] || lim;
    state_n = state;
    owner_n = owner;
    ptr_n = ptr;
    cnt_n = &cnt ? cnt : cnt + 1'b1;
    if (rel) begin
      state_n = found ? OWN : IDLE;
      owner_n = found ? win : '0;
      ptr_n = found ? (win == W'(N - 1) ? '0 : win + 1'b1) : ptr;
      cnt_n = found ? CW'(1) : '0;
    end
  end
  always_comb begin
    bus.grant = '0;
    bus.grant[owner] = state == OWN;
    bus.grant_id = owner;
    bus.busy = state == OWN;
    bus.burst_cnt = cnt;
  end
endmodule

// File: tb/tb_burst_rr_arbiter.sv
// tb_burst_rr_arbiter: scoreboard bench for burst_rr_arbiter with N=4, MAX_BURST=4
module tb_burst_rr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [9:0] sb[$];
  burst_rr_arbiter_if #(.N(4), .MAX_BURST(4)) bus ();
  burst_rr_arbiter #(.N(4), .MAX_BURST(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  function automatic logic [9:0] mk(input logic [3:0] g, input logic [2:0] c);
    logic [1:0] id;
    id = g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
    return {|g, g, id, c};
  endfunction

  function automatic logic [9:0] got();
    return {bus.busy, bus.grant, bus.grant_id, bus.burst_cnt};
  endfunction

  task automatic drive(input logic r_s, input logic [3:0] r, input logic [3:0] l,
                       input logic [3:0] eg, input logic [2:0] ec);
    rst = r_s;
    bus.request = r;
    bus.last = l;
    sb.push_back(mk(eg, ec));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    drive(1'b1, 4'b1111, 4'b0000, 4'b0000, 3'd0);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(1'b1, 4'b1111, 4'b0000, 4'b0000, 3'd0);
      else drive(1'b0, 4'b1111, 4'b0000, 4'b0001, 3'd1);
      void'(sb.pop_front());
      e = sb.pop_front();
      sb.push_front(e);
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin
        errors++;
        $display("FAIL reset step %0d: got %b want %b", i, got(), e);
      end
      sb.push_front(10'd0);
    end
    sb.delete();
  endtask

  task automatic test_rotation();
    logic [3:0] g[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [9:0] e;
    drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 3'd0);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'b1111, 4'b1111, g[i], 3'd1);
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin
        errors++;
        $display("FAIL rotation step %0d: got %b want %b", i, got(), e);
      end
    end
  endtask

  task automatic test_burst_limit();
    logic [9:0] e;
    logic [3:0] g;
    logic [2:0] c;
    drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 3'd0);
    void'(sb.pop_front());
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_BURST_LIMIT_EN
      g = ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
      c = 3'(i % 4 + 1);
`else
      g = 4'b0001;
      c = (i < 7) ? 3'(i + 1) : 3'd7;
`endif
      drive(1'b0, 4'b0011, 4'b0000, g, c);
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin
        errors++;
        $display("FAIL burst_limit step %0d: got %b want %b", i, got(), e);
      end
    end
  endtask

  task automatic test_request_drop();
    logic [3:0] nr[2] = '{4'b0000, 4'b1001};
    logic [3:0] ng[2] = '{4'b0000, 4'b1000};
    logic [9:0] e;
    for (int v = 0; v < 2; v++) begin
      drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 3'd0);
      void'(sb.pop_front());
      drive(1'b0, 4'b0100, 4'b0000, 4'b0100, 3'd1);
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin
        errors++;
        $display("FAIL drop_own%0d: got %b want %b", v, got(), e);
      end
      drive(1'b0, nr[v], 4'b0000, ng[v], ng[v] == 4'b0000 ? 3'd0 : 3'd1);
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin
        errors++;
        $display("FAIL drop_next%0d: got %b want %b", v, got(), e);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] r[5] = '{4'b0010, 4'b0010, 4'b0010, 4'b1010, 4'b1010};
    logic [3:0] g[5] = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010};
    logic [2:0] c[5] = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
    logic [9:0] e;
    drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 3'd0);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive(i == 2, r[i], 4'b0000, g[i], c[i]);
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin
        errors++;
        $display("FAIL mid_reset step %0d: got %b want %b", i, got(), e);
      end
    end
  endtask

  task automatic test_sole();
    logic [3:0] l[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
    logic [2:0] c[5] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2};
    logic [9:0] e;
    drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 3'd0);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'b0100, l[i], 4'b0100, c[i]);
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin
        errors++;
        $display("FAIL sole step %0d: got %b want %b", i, got(), e);
      end
    end
  endtask

  task automatic test_nonowner();
    logic [3:0] r[3] = '{4'b0011, 4'b1011, 4'b0111};
    logic [3:0] l[3] = '{4'b0000, 4'b0010, 4'b1110};
    logic [9:0] e;
    drive(1'b1, 4'b0000, 4'b0000, 4'b0000, 3'd0);
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, r[i], l[i], 4'b0001, 3'(i + 1));
      e = sb.pop_front();
      checks++;
      if (got() !== e) begin
        errors++;
        $display("FAIL nonowner step %0d: got %b want %b", i, got(), e);
      end
    end
  endtask

  initial begin
    bus.request = '0;
    bus.last = '0;
    test_reset();
    test_rotation();
    test_burst_limit();
    test_request_drop();
    test_mid_reset();
    test_sole();
    test_nonowner();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
